// File: rtl/regfile_writeback_ctrl_if.sv
// Bundle of signals between the write-back controller and its neighbours:
// the ALU and load result producers, the issue-stage hazard query, and the
// register-file write port.
//   master : the environment (producers, issue stage, register file)
//   slave  : regfile_writeback_ctrl
// Parameters: size  = data width, DEPTH = load queue depth (power of two, >= 2)
interface regfile_writeback_ctrl_if #(
  parameter int size  = 32,
  parameter int DEPTH = 4
);
  // ALU result (always accepted)
  logic                       alu_valid;
  logic [4:0]                 alu_rd;
  logic [size-1:0]            alu_data;
  // Load result (valid/ready handshake)
  logic                       ld_valid;
  logic                       ld_ready;
  logic [4:0]                 ld_rd;
  logic [size-1:0]            ld_data;
  // Issue-stage hazard query
  logic [4:0]                 query_reg_1;
  logic [4:0]                 query_reg_2;
  logic                       pend_1;
  logic                       pend_2;
  // Register-file write port
  logic                       reg_write;
  logic [4:0]                 write_register;
  logic [size-1:0]            write_data;
  // Load queue occupancy
  logic [$clog2(DEPTH):0]     queue_count;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data,
    output query_reg_1, query_reg_2,
    input  ld_ready, pend_1, pend_2,
    input  reg_write, write_register, write_data, queue_count
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data,
    input  query_reg_1, query_reg_2,
    output ld_ready, pend_1, pend_2,
    output reg_write, write_register, write_data, queue_count
  );
endinterface

// File: rtl/regfile_writeback_ctrl.sv
// Write-back controller owning the single register-file write port.
// Merges the ALU (single cycle, strict priority) and a buffered load path
// into one registered write per cycle. Outputs change on posedge so the
// register file can sample them at the following negedge.
// Ports:
//   clk   : clock, all state updates on posedge
//   reset : synchronous active-high reset
//   bus   : regfile_writeback_ctrl_if.slave (ALU in, load in with ready,
//           hazard query/pend, register-file write port, queue_count)
module regfile_writeback_ctrl #(
  parameter int size  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  regfile_writeback_ctrl_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Load queue storage
  logic [DEPTH-1:0]  q_valid_reg;
  logic [DEPTH-1:0]  q_valid_next;
  logic [4:0]        q_rd_reg   [DEPTH];
  logic [size-1:0]   q_data_reg [DEPTH];
  logic [PW-1:0]     head_reg;
  logic [PW-1:0]     tail_reg;
  logic [CW-1:0]     count_reg;

  // Output registers
  logic              reg_write_reg;
  logic [4:0]        write_register_reg;
  logic [size-1:0]   write_data_reg;

  logic              push;
  logic              pop;
  logic              ready;
  logic [DEPTH-1:0]  match_1;
  logic [DEPTH-1:0]  match_2;

  // Full means not ready, even if a pop would free a slot this cycle.
  assign ready = (count_reg < CW'(DEPTH));
  assign push  = bus.ld_valid && ready;
  // The ALU owns the port whenever it has a result; the queue waits.
  assign pop   = !bus.alu_valid && (count_reg != '0);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Hazard match only on live entries; popped slots are cleared below.
      assign match_1[gi] = q_valid_reg[gi] && (q_rd_reg[gi] == bus.query_reg_1);
      assign match_2[gi] = q_valid_reg[gi] && (q_rd_reg[gi] == bus.query_reg_2);

      // A push lands in a free slot and is younger than the ALU result, so
      // it wins over the kill. Otherwise a matching ALU write kills the entry
      // (WAW) and a pop retires it.
      always_comb begin
        q_valid_next[gi] = q_valid_reg[gi];
        if (push && (tail_reg == PW'(gi))) begin
          q_valid_next[gi] = 1'b1;
        end else if (pop && (head_reg == PW'(gi))) begin
          q_valid_next[gi] = 1'b0;
        end else if (bus.alu_valid && (q_rd_reg[gi] == bus.alu_rd)) begin
          q_valid_next[gi] = 1'b0;
        end
      end
    end
  endgenerate

  // Queue payload: written only on push, never needs a reset value because
  // the valid bits and counter gate every use.
  always_ff @(posedge clk) begin
    if (push) begin
      q_rd_reg[tail_reg]   <= bus.ld_rd;
      q_data_reg[tail_reg] <= bus.ld_data;
    end
  end

  // Queue control
  always_ff @(posedge clk) begin
    if (reset) begin
      q_valid_reg <= '0;
      head_reg    <= '0;
      tail_reg    <= '0;
      count_reg   <= '0;
    end else begin
      q_valid_reg <= q_valid_next;
      if (push) begin
        tail_reg <= tail_reg + PW'(1);
      end
      if (pop) begin
        head_reg <= head_reg + PW'(1);
      end
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

  // Write port: ALU first, then queue head (a killed head retires silently),
  // otherwise idle with address/data held.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write_reg      <= 1'b0;
      write_register_reg <= '0;
      write_data_reg     <= '0;
    end else if (bus.alu_valid) begin
      reg_write_reg      <= 1'b1;
      write_register_reg <= bus.alu_rd;
      write_data_reg     <= bus.alu_data;
    end else if (pop) begin
      reg_write_reg      <= q_valid_reg[head_reg];
      write_register_reg <= q_rd_reg[head_reg];
      write_data_reg     <= q_data_reg[head_reg];
    end else begin
      reg_write_reg      <= 1'b0;
    end
  end

  assign bus.ld_ready       = ready;
  assign bus.pend_1         = |match_1;
  assign bus.pend_2         = |match_2;
  assign bus.reg_write      = reg_write_reg;
  assign bus.write_register = write_register_reg;
  assign bus.write_data     = write_data_reg;
  assign bus.queue_count    = count_reg;
endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
module tb_regfile_writeback_ctrl;
  localparam int SZ = 32;
  localparam int DP = 4;

  logic clk;
  logic reset;

  regfile_writeback_ctrl_if #(.size(SZ), .DEPTH(DP)) bus ();

  regfile_writeback_ctrl #(.size(SZ), .DEPTH(DP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: an ordered list of pending loads plus the write port.
  typedef struct {
    logic        v;
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;
  ent_t        mq[$];
  logic        m_we;
  logic [4:0]  m_wr;
  logic [31:0] m_wd;

  typedef struct {
    logic        rst;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adata;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldata;
    logic        e_we;
    logic [4:0]  e_wr;
    logic [31:0] e_wd;
    int          e_cnt;
    logic        e_rdy;
  } vec_t;
  vec_t vec[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic av, input logic [4:0] ard,
                       input logic [31:0] adata, input logic lv,
                       input logic [4:0] lrd, input logic [31:0] ldata);
    reset         = rst;
    bus.alu_valid = av;
    bus.alu_rd    = ard;
    bus.alu_data  = adata;
    bus.ld_valid  = lv;
    bus.ld_rd     = lrd;
    bus.ld_data   = ldata;
  endtask

  // Called 1 time unit after a posedge with inputs already driven.
  // Checks combinational outputs mid-cycle, advances the model by the rules
  // of the block, then checks the registered outputs after the edge.
  task automatic step();
    logic exp_rdy, p1, p2, push;
    ent_t e;
    #3;
    exp_rdy = (mq.size() < DP);
    p1 = 1'b0;
    p2 = 1'b0;
    foreach (mq[i]) begin
      if (mq[i].v && mq[i].rd == bus.query_reg_1) p1 = 1'b1;
      if (mq[i].v && mq[i].rd == bus.query_reg_2) p2 = 1'b1;
    end
    chk("ld_ready", bus.ld_ready, exp_rdy);
    chk("pend_1", bus.pend_1, p1);
    chk("pend_2", bus.pend_2, p2);
    chk("count_pre", bus.queue_count, mq.size());
    push = bus.ld_valid && exp_rdy;
    if (reset) begin
      mq.delete();
      m_we = 1'b0;
      m_wr = '0;
      m_wd = '0;
    end else begin
      if (bus.alu_valid) begin
        foreach (mq[i]) if (mq[i].rd == bus.alu_rd) mq[i].v = 1'b0;
        m_we = 1'b1;
        m_wr = bus.alu_rd;
        m_wd = bus.alu_data;
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        m_we = e.v;
        m_wr = e.rd;
        m_wd = e.d;
      end else begin
        m_we = 1'b0;
      end
      if (push) begin
        e.v = 1'b1;
        e.rd = bus.ld_rd;
        e.d = bus.ld_data;
        mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    chk("reg_write", bus.reg_write, m_we);
    chk("write_register", bus.write_register, m_wr);
    chk("write_data", bus.write_data, m_wd);
    chk("count_post", bus.queue_count, mq.size());
  endtask

  initial begin
    // rst av ard adata lv lrd ldata | we wr wd cnt rdy
    vec[0]  = '{1, 0, 0,  0,            1, 9, 32'h99, 0, 0,  0,            0, 1};
    vec[1]  = '{1, 0, 0,  0,            1, 9, 32'h99, 0, 0,  0,            0, 1};
    vec[2]  = '{0, 1, 5,  32'hDEADBEEF, 0, 0, 0,      1, 5,  32'hDEADBEEF, 0, 1};
    vec[3]  = '{0, 0, 0,  0,            0, 0, 0,      0, 5,  32'hDEADBEEF, 0, 1};
    vec[4]  = '{0, 1, 10, 32'h100,      1, 1, 32'h11, 1, 10, 32'h100,      1, 1};
    vec[5]  = '{0, 1, 11, 32'h101,      1, 2, 32'h22, 1, 11, 32'h101,      2, 1};
    vec[6]  = '{0, 1, 12, 32'h102,      1, 3, 32'h33, 1, 12, 32'h102,      3, 1};
    vec[7]  = '{0, 1, 13, 32'h103,      1, 4, 32'h44, 1, 13, 32'h103,      4, 0};
    vec[8]  = '{0, 1, 14, 32'h104,      1, 6, 32'h55, 1, 14, 32'h104,      4, 0};
    vec[9]  = '{0, 0, 0,  0,            0, 0, 0,      1, 1,  32'h11,       3, 1};
    vec[10] = '{0, 0, 0,  0,            0, 0, 0,      1, 2,  32'h22,       2, 1};
    vec[11] = '{0, 0, 0,  0,            0, 0, 0,      1, 3,  32'h33,       1, 1};
    vec[12] = '{0, 0, 0,  0,            0, 0, 0,      1, 4,  32'h44,       0, 1};
    vec[13] = '{0, 0, 0,  0,            0, 0, 0,      0, 4,  32'h44,       0, 1};
    vec[14] = '{0, 1, 0,  32'h5,        0, 0, 0,      1, 0,  32'h5,        0, 1};

    bus.query_reg_1 = 5'd31;
    bus.query_reg_2 = 5'd30;
    drive(1, 0, 0, 0, 0, 0, 0);
    m_we = 1'b0;
    m_wr = '0;
    m_wd = '0;
    @(posedge clk);
    #1;

    // Table-driven directed vectors
    for (int i = 0; i < 15; i++) begin
      drive(vec[i].rst, vec[i].av, vec[i].ard, vec[i].adata,
            vec[i].lv, vec[i].lrd, vec[i].ldata);
      step();
      chk($sformatf("vec%0d_we", i), bus.reg_write, vec[i].e_we);
      chk($sformatf("vec%0d_wr", i), bus.write_register, vec[i].e_wr);
      chk($sformatf("vec%0d_wd", i), bus.write_data, vec[i].e_wd);
      chk($sformatf("vec%0d_cnt", i), bus.queue_count, vec[i].e_cnt);
      chk($sformatf("vec%0d_rdy", i), bus.ld_ready, vec[i].e_rdy);
    end

    // WAW kill: queued r7 load is superseded by an ALU write to r7
    bus.query_reg_1 = 5'd7;
    drive(0, 0, 0, 0, 1, 7, 32'hAA);
    step();
    chk("waw_pend_before", bus.pend_1, 1'b1);
    chk("waw_cnt_queued", bus.queue_count, 1);
    drive(0, 1, 7, 32'hBB, 0, 0, 0);
    step();
    chk("waw_alu_we", bus.reg_write, 1'b1);
    chk("waw_alu_data", bus.write_data, 32'hBB);
    chk("waw_pend_after", bus.pend_1, 1'b0);
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    chk("waw_killed_pop_we", bus.reg_write, 1'b0);
    chk("waw_cnt_drained", bus.queue_count, 0);

    // Simultaneous push/pop with pointer wrap
    drive(0, 0, 0, 0, 1, 3, 32'h300);
    step();
    for (int k = 0; k < 7; k++) begin
      drive(0, 0, 0, 0, 1, 5'(k + 16), 32'h1000 + k);
      step();
      chk("simul_cnt", bus.queue_count, 1);
      chk("simul_wr", bus.write_register, (k == 0) ? 64'd3 : 64'(k + 15));
      chk("simul_we", bus.reg_write, 1'b1);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    step();

    // Reset mid-stream discards queued loads
    bus.query_reg_1 = 5'd20;
    bus.query_reg_2 = 5'd22;
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 30, 32'h77, 1, 5'(20 + k), 32'h200 + k);
      step();
    end
    chk("mid_cnt3", bus.queue_count, 3);
    chk("mid_pend_1", bus.pend_1, 1'b1);
    drive(1, 0, 0, 0, 0, 0, 0);
    step();
    chk("mid_rst_cnt", bus.queue_count, 0);
    chk("mid_rst_pend_2", bus.pend_2, 1'b0);
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    chk("mid_no_stale_we", bus.reg_write, 1'b0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      bus.query_reg_1 = 5'($urandom_range(0, 7));
      bus.query_reg_2 = 5'($urandom_range(0, 7));
      drive(($urandom_range(0, 39) == 0),
            ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
